// File: rtl/card_grid_pkg.sv
// card_grid_pkg: card state encoding, per-channel palette masks and colour helper for card_grid_renderer.
package card_grid_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, HIDDEN = 2'b01, REVEALED = 2'b10, MATCHED = 2'b11} card_state_t;
  // bit s of each mask: channel lit for symbol s (magenta, cyan, yellow, red, lime, blue, white, white)
  localparam logic [7:0] PAL_R = 8'b1100_1101;
  localparam logic [7:0] PAL_G = 8'b1101_0110;
  localparam logic [7:0] PAL_B = 8'b1110_0011;
  localparam int BORDER_PX = 3;
  localparam int CW_MAX = 16;
  function automatic logic [CW_MAX-1:0] shade(input logic on, input logic half, input int cw);
    logic [CW_MAX-1:0] full;
    full = CW_MAX'((32'd1 << cw) - 32'd1);
    return on ? (half ? full >> 1 : full) : '0;
  endfunction
endpackage

// File: rtl/card_grid_renderer_if.sv
// card_grid_renderer_if: raster timing in from the vga generator, pixel/sync out to the DAC.
interface card_grid_renderer_if #(parameter int CW = 10);
  logic [9:0] sx, sy;
  logic hsync, vsync, de;
  logic [CW-1:0] vga_r, vga_g, vga_b;
  logic vga_hsync, vga_vsync, vga_blank;
  modport master (output sx, sy, hsync, vsync, de, input vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank);
  modport slave (input sx, sy, hsync, vsync, de, output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank);
endinterface

// File: rtl/grid_axis_counter.sv
// grid_axis_counter: offset/index/run tracker for one raster axis; outputs describe the current position.
module grid_axis_counter #(
  parameter int START = 20,
  parameter int SIZE = 104,
  parameter int PITCH = 124,
  parameter int COUNT = 5
) (
  input  logic clock_25M,
  input  logic reset_n,
  input  logic step,
  input  logic [9:0] pos,
  output logic [$clog2(PITCH)-1:0] off,
  output logic [$clog2(COUNT+1)-1:0] idx,
  output logic hit
);
  localparam int OW = $clog2(PITCH);
  localparam int NW = $clog2(COUNT+1);
  logic [OW-1:0] off_q;
  logic [NW-1:0] idx_q;
  logic run_q, run, wrap;
  // registers hold the last stepped position, so a step is folded in combinationally
  always_comb begin
    wrap = int'(off_q) == PITCH - 1;
    off = off_q;
    idx = idx_q;
    run = run_q;
    if (step) begin
      if (pos == 10'(START)) begin
        off = '0;
        idx = '0;
        run = 1'b1;
      end else if (pos == '0) run = 1'b0;
      else if (run_q) begin
        off = wrap ? '0 : off_q + 1'b1;
        idx = wrap ? idx_q + 1'b1 : idx_q;
        run = !(wrap && idx_q == NW'(COUNT - 1));
      end
    end
    hit = run && int'(off) < SIZE;
  end
  always_ff @(posedge clock_25M)
    if (!reset_n) begin
      off_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      off_q <= off;
      idx_q <= idx;
      run_q <= run;
    end
endmodule

// File: rtl/card_grid_renderer.sv
// card_grid_renderer: 2-stage pipelined COLS x ROWS card painter for a 640x480 raster.
// Define CARD_CURSOR_BORDER_EN to outline the cursor card in white.
module card_grid_renderer import card_grid_pkg::*; #(
  parameter int COLS = 5,
  parameter int ROWS = 4,
  parameter int CARD_W = 104,
  parameter int CARD_H = 95,
  parameter int GAP = 20,
  parameter int ORIGIN_X = 20,
  parameter int ORIGIN_Y = 20,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW = 10,
  localparam int N = COLS * ROWS,
  localparam int IW = $clog2(N)
) (
  input logic clock_25M,
  input logic reset_n,
  card_grid_renderer_if.slave vif,
  input logic [2*N-1:0] card_state,
  input logic [3*N-1:0] card_sym,
  input logic [IW-1:0] cursor_idx
);
  localparam int PX = CARD_W + GAP;
  localparam int PY = CARD_H + GAP;
  if (ORIGIN_X + COLS*PX - GAP > H_ACTIVE || ORIGIN_Y + ROWS*PY - GAP > V_ACTIVE || CW < 2 || CW > CW_MAX || N < 2) begin : g_bad_params
    $error("card_grid_renderer: grid exceeds raster or CW out of range");
  end
  logic [$clog2(PX)-1:0] xoff;
  logic [$clog2(PY)-1:0] yoff;
  logic [$clog2(COLS+1)-1:0] xidx;
  logic [$clog2(ROWS+1)-1:0] yidx;
  logic xhit, yhit, frame, white, in1, de1, hs1, vs1, lit, half;
  logic [IW-1:0] k1;
  logic [2*N-1:0] state_sh;
  logic [3*N-1:0] sym_sh;
  card_state_t st;
  logic [2:0] sym, on;
  grid_axis_counter #(.START(ORIGIN_X), .SIZE(CARD_W), .PITCH(PX), .COUNT(COLS)) u_x (
    .clock_25M(clock_25M), .reset_n(reset_n), .step(1'b1), .pos(vif.sx), .off(xoff), .idx(xidx), .hit(xhit));
  grid_axis_counter #(.START(ORIGIN_Y), .SIZE(CARD_H), .PITCH(PY), .COUNT(ROWS)) u_y (
    .clock_25M(clock_25M), .reset_n(reset_n), .step(vif.sx == '0), .pos(vif.sy), .off(yoff), .idx(yidx), .hit(yhit));
  assign frame = vif.sy == 10'(V_ACTIVE) && vif.sx == '0;
  always_ff @(posedge clock_25M)
    if (!reset_n) begin
      in1 <= 1'b0;
      k1 <= '0;
      de1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
    end else begin
      in1 <= xhit && yhit;
      k1 <= IW'(int'(yidx) * COLS + int'(xidx));
      de1 <= vif.de;
      hs1 <= vif.hsync;
      vs1 <= vif.vsync;
    end
  // shadow only moves at the frame pulse so a frame never mixes old and new state
  always_ff @(posedge clock_25M)
    if (!reset_n) begin
      state_sh <= '0;
      sym_sh <= '0;
    end else if (frame) begin
      state_sh <= card_state;
      sym_sh <= card_sym;
    end
`ifdef CARD_CURSOR_BORDER_EN
  logic [IW-1:0] cursor_sh;
  logic cur_on, edge1;
  always_ff @(posedge clock_25M)
    if (!reset_n) begin
      cursor_sh <= '0;
      cur_on <= 1'b0;
      edge1 <= 1'b0;
    end else begin
      if (frame) begin
        cursor_sh <= cursor_idx;
        cur_on <= int'(cursor_idx) < N;
      end
      edge1 <= int'(xoff) < BORDER_PX || int'(xoff) >= CARD_W - BORDER_PX ||
               int'(yoff) < BORDER_PX || int'(yoff) >= CARD_H - BORDER_PX;
    end
  assign white = in1 && edge1 && cur_on && cursor_sh == k1;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_idx, xoff, yoff};
  assign white = 1'b0;
`endif
  always_comb begin
    st = card_state_t'(state_sh[2*k1 +: 2]);
    sym = sym_sh[3*k1 +: 3];
    lit = in1 && (st == REVEALED || st == MATCHED);
    half = !white && lit && st == MATCHED;
    on = white ? 3'b111 : (in1 && st == HIDDEN) ? 3'b101 : lit ? {PAL_R[sym], PAL_G[sym], PAL_B[sym]} : 3'b000;
  end
  always_ff @(posedge clock_25M)
    if (!reset_n) begin
      vif.vga_r <= '0;
      vif.vga_g <= '0;
      vif.vga_b <= '0;
      vif.vga_hsync <= 1'b1;
      vif.vga_vsync <= 1'b1;
      vif.vga_blank <= 1'b0;
    end else begin
      vif.vga_r <= de1 ? CW'(shade(on[2], half, CW)) : '0;
      vif.vga_g <= de1 ? CW'(shade(on[1], half, CW)) : '0;
      vif.vga_b <= de1 ? CW'(shade(on[0], half, CW)) : '0;
      vif.vga_hsync <= hs1;
      vif.vga_vsync <= vs1;
      vif.vga_blank <= de1;
    end
endmodule
